// File: rtl/tinyproc_pkg.sv
// Shared constants and the transmitter state encoding.
package tinyproc_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 4;
    localparam int unsigned DATA_W               = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/result_uart_tx_if.sv
// Result-in / serial-out signal bundle of the result UART.
interface result_uart_tx_if;
    import tinyproc_pkg::*;

    logic [DATA_W-1:0] result;
    logic              tx;
    logic              busy;
    logic              overflow;

    modport master (output result, input tx, input busy, input overflow);
    modport slave  (input result, output tx, output busy, output overflow);
endinterface

// File: rtl/byte_fifo.sv
// Small byte queue; a push into a full queue is accepted only when a pop
// happens on the same edge.
module byte_fifo
    import tinyproc_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push_ok_c;
    logic              pop_ok_c;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pop_ok_c  = pop && !empty;
    assign push_ok_c = push && (!full || pop_ok_c);
    assign dout      = mem[rd_ptr];

    // Storage array; no reset needed since empty gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// Streams every change of the processor result register out as an 8N1 frame.
module result_uart_tx
    import tinyproc_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    result_uart_tx_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] prev_result;
    logic              tx_q;
    logic              overflow_q;

    logic              change_c;
    logic              pop_c;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    assign change_c = (bus.result != prev_result);
    assign pop_c    = (state == IDLE) && !fifo_empty;

    assign bus.tx       = tx_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state != IDLE) || !fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (change_c),
        .din   (bus.result),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Previous-value register used for change detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_result <= '0;
        end else begin
            prev_result <= bus.result;
        end
    end

    // Sticky overflow: a change was lost to a full queue with no pop that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (change_c && fifo_full && !pop_c) begin
            overflow_q <= 1'b1;
        end
    end

    // Transmitter FSM with registered serial output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q     <= 1'b1;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop_c) begin
                        shreg <= fifo_dout;
                        tx_q  <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= shreg[0];
                        shreg    <= shreg >> 1;
                        state    <= DATA;
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: frame-level reference model of queue and line.
module tb_result_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic clk;
    logic reset;

    result_uart_tx_if bus ();

    result_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: pending bytes, current frame and its elapsed time.
    logic [7:0]  q [$];
    logic [7:0]  m_prev;
    logic [7:0]  m_cur;
    bit          m_active;
    int unsigned m_t;
    bit          m_ovf;
    logic        exp_tx;
    logic        exp_busy;
    logic        exp_ovf;

    function automatic logic line_at(int unsigned t, logic [7:0] b);
        int unsigned k;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    function automatic void model_outputs();
        exp_tx   = m_active ? line_at(m_t, m_cur) : 1'b1;
        exp_busy = m_active || (q.size() > 0);
        exp_ovf  = m_ovf;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_prev   = 8'h00;
        m_cur    = 8'h00;
        m_active = 1'b0;
        m_t      = 0;
        m_ovf    = 1'b0;
        model_outputs();
    endfunction

    function automatic void model_edge(logic [7:0] r);
        int  old;
        bit  deq;
        old = q.size();
        deq = 1'b0;
        if (m_active) begin
            m_t++;
            if (m_t == FRAME) m_active = 1'b0;
        end else if (old > 0) begin
            m_cur    = q.pop_front();
            m_active = 1'b1;
            m_t      = 0;
            deq      = 1'b1;
        end
        if (r != m_prev) begin
            if (old < int'(DEPTH) || deq) q.push_back(r);
            else m_ovf = 1'b1;
        end
        m_prev = r;
        model_outputs();
    endfunction

    // One clock: update the model at the edge, return 1 time unit later.
    task automatic advance();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(bus.result);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.result = 8'h00;
        model_reset();
        #1;
        vectors++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: tx/busy/ovf got %b%b%b want 100", bus.tx, bus.busy, bus.overflow);
        end
        advance();
        advance();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            advance();
            vectors++;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold cyc %0d: tx/busy/ovf got %b%b%b want 100", i, bus.tx, bus.busy, bus.overflow);
            end
        end
    endtask

    task automatic test_single_a5();
        logic [9:0] pattern;
        pattern = 10'b1101001010;
        bus.result = 8'hA5;
        advance();
        for (int i = 0; i < int'(FRAME) + 3; i++) begin
            advance();
            vectors++;
            if (i < int'(FRAME) && bus.tx !== pattern[i / int'(CPB)]) begin
                miscompares++;
                $display("FAIL a5_pattern cyc %0d: tx got %b want %b", i, bus.tx, pattern[i / int'(CPB)]);
            end else if (bus.tx !== exp_tx || bus.busy !== exp_busy || bus.overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL a5_model cyc %0d: tx/busy/ovf got %b%b%b want %b%b%b",
                         i, bus.tx, bus.busy, bus.overflow, exp_tx, exp_busy, exp_ovf);
            end
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL a5_busy_fall: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int v = 1; v <= 3; v++) begin
            bus.result = 8'(v);
            advance();
            vectors++;
            if (bus.tx !== exp_tx || bus.busy !== exp_busy || bus.overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL b2b_load %0d: tx/busy/ovf got %b%b%b want %b%b%b",
                         v, bus.tx, bus.busy, bus.overflow, exp_tx, exp_busy, exp_ovf);
            end
        end
        for (int i = 0; i < 3 * int'(FRAME) + 8; i++) begin
            advance();
            vectors++;
            if (bus.tx !== exp_tx || bus.busy !== exp_busy || bus.overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL b2b cyc %0d: tx/busy/ovf got %b%b%b want %b%b%b",
                         i, bus.tx, bus.busy, bus.overflow, exp_tx, exp_busy, exp_ovf);
            end
        end
    endtask

    task automatic test_same_value();
        bus.result = 8'h3C;
        for (int i = 0; i < 2 * int'(FRAME) + 4; i++) begin
            if (i == 5) bus.result = 8'h3C;
            advance();
            vectors++;
            if (bus.tx !== exp_tx || bus.busy !== exp_busy || bus.overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL same_value cyc %0d: tx/busy/ovf got %b%b%b want %b%b%b",
                         i, bus.tx, bus.busy, bus.overflow, exp_tx, exp_busy, exp_ovf);
            end
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL same_value_single: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_overflow();
        bus.result = 8'h10;
        advance();
        advance();
        advance();
        for (int v = 1; v <= 6; v++) begin
            bus.result = 8'(8'h10 + v);
            advance();
            vectors++;
            if (bus.tx !== exp_tx || bus.busy !== exp_busy || bus.overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL ovf_burst %0d: tx/busy/ovf got %b%b%b want %b%b%b",
                         v, bus.tx, bus.busy, bus.overflow, exp_tx, exp_busy, exp_ovf);
            end
        end
        vectors++;
        if (bus.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: overflow got %b want 1", bus.overflow);
        end
        for (int i = 0; i < 5 * (int'(FRAME) + 1) + 4; i++) begin
            advance();
            vectors++;
            if (bus.tx !== exp_tx || bus.busy !== exp_busy || bus.overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL ovf_drain cyc %0d: tx/busy/ovf got %b%b%b want %b%b%b",
                         i, bus.tx, bus.busy, bus.overflow, exp_tx, exp_busy, exp_ovf);
            end
        end
        vectors++;
        if (bus.overflow !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_sticky: ovf/busy got %b%b want 10", bus.overflow, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        bit reached;
        reached = 1'b0;
        bus.result = 8'h5A;
        for (int i = 0; i < 100 && !reached; i++) begin
            advance();
            if (m_active && m_t == 4 * CPB + 1) reached = 1'b1;
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL mid_reach: bit 3 got not reached want reached");
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_async: tx/busy/ovf got %b%b%b want 100", bus.tx, bus.busy, bus.overflow);
        end
        advance();
        advance();
        reset = 1'b0;
        for (int i = 0; i < int'(FRAME) + 4; i++) begin
            advance();
            vectors++;
            if (bus.tx !== exp_tx || bus.busy !== exp_busy || bus.overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL mid_refresh cyc %0d: tx/busy/ovf got %b%b%b want %b%b%b",
                         i, bus.tx, bus.busy, bus.overflow, exp_tx, exp_busy, exp_ovf);
            end
        end
    endtask

    task automatic test_random();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 99);
            if (sel < 4) bus.result = 8'($urandom);
            else if (sel < 6) bus.result = bus.result;
            else if (sel < 8) bus.result = bus.result + 8'd1;
            advance();
            vectors++;
            if (bus.tx !== exp_tx || bus.busy !== exp_busy || bus.overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL random cyc %0d: tx/busy/ovf got %b%b%b want %b%b%b",
                         i, bus.tx, bus.busy, bus.overflow, exp_tx, exp_busy, exp_ovf);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_same_value();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit period (legal range 2..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving pending-byte queue entries (power of two, 2..16).
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: result  input  8  processor result register (updated by stores to data address 0).
REQ-006 Port: tx  output  1  serial line, 8N1, idle high.
REQ-007 Port: busy  output  1  high while a frame is in flight or the queue is non-empty.
REQ-008 Port: overflow  output  1  sticky flag; a changed result value was dropped because the queue was full.

Function
REQ-009 The block SHALL hold a previous-value register prev_result, updated from result every cycle.
REQ-010 The block SHALL enqueue result on a rising edge where result != prev_result; equal values SHALL NOT be enqueued.
REQ-011 The queue SHALL be FIFO ordered with FIFO_DEPTH entries; pointer wrap-around SHALL NOT lose or duplicate entries.
REQ-012 The transmitter FSM SHALL have states IDLE, START, DATA, STOP.
REQ-013 IDLE with a non-empty queue SHALL dequeue the head into a shift register and enter START on the same edge; otherwise it SHALL remain in IDLE.
REQ-014 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-015 DATA SHALL drive 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit counter, then enter STOP.
REQ-016 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then enter IDLE.
REQ-017 In IDLE, tx SHALL be 1.
REQ-018 tx SHALL be driven from a register (glitch-free).
REQ-019 Back-to-back frames SHALL have exactly one idle cycle between the stop bit's end and the next start bit.
REQ-020 Latency: a change sampled at edge E SHALL be written to the queue at E, with tx low from edge E+1 when the FSM is IDLE and the queue was empty.
REQ-021 Enqueue and dequeue on the same edge SHALL both take effect; occupancy SHALL be unchanged.
REQ-022 A change arriving while the queue is full SHALL be dropped and SHALL set overflow, unless a dequeue occurs on the same edge, in which case it SHALL be accepted.
REQ-023 overflow SHALL remain 1 until reset.
REQ-024 busy SHALL equal (state != IDLE) OR (queue not empty), registered or combinational from registered state.
REQ-025 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 with no wrap within a bit.

Reset
REQ-026 Asserting reset SHALL immediately set tx=1, busy=0, overflow=0, state=IDLE, queue empty, prev_result=0 and counters=0, aborting any frame mid-transmission.
REQ-027 After reset deasserts, a nonzero result SHALL be treated as a change at the first edge and enqueued.

Structure
REQ-028 Shared package tinyproc_pkg SHALL hold the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT constant.
REQ-029 The queue SHALL be a separate sub-module byte_fifo (8-bit data, push, pop, full, empty, asynchronous active-high reset).
REQ-030 The top level SHALL contain change detection, the FSM, the bit and period counters, and the overflow flag.

Verification
REQ-031 Reset, result held 0 for 100 cycles -> tx stays 1, busy=0, no frame.
REQ-032 CLKS_PER_BIT=4, result 0->0xA5 -> tx low at E+1; line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy falls after stop.
REQ-033 result 0x01,0x02,0x03 on consecutive cycles -> three frames in that order, each separated by one idle cycle.
REQ-034 Depth 4, frame in flight, 6 rapid changes -> 4 queued, later ones dropped, overflow=1 and remains 1 after drain.
REQ-035 reset asserted mid-DATA bit 3 -> tx=1 immediately; after release with result unchanged nonzero -> one fresh frame of that value.
REQ-036 Store of the same value twice (result unchanged) -> exactly one frame.
